// File: rtl/gpio_debounced_controller.sv
// gpio_debounced_controller: APB3 GPIO with LED set/clear, debounced keys, sticky edge flags and level irq
module gpio_debounced_controller #(
  parameter int LED_COUNT = 3,
  parameter int KEY_COUNT = 2,
  parameter logic [LED_COUNT-1:0] LED_INVERT = '0,
  parameter logic [KEY_COUNT-1:0] KEY_INVERT = '0,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [LED_COUNT-1:0] leds,
  input  logic [KEY_COUNT-1:0] keys,
  output logic                 irq,
  input  logic [4:0]           apb_PADDR,
  input  logic                 apb_PSEL,
  input  logic                 apb_PENABLE,
  output logic                 apb_PREADY,
  input  logic                 apb_PWRITE,
  input  logic [31:0]          apb_PWDATA,
  output logic [31:0]          apb_PRDATA
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  logic [LED_COUNT-1:0] led_reg;
  logic [KEY_COUNT-1:0] sync_a, sync_b, state, hit, rise, fall;
  logic [KEY_COUNT-1:0] rise_f, fall_f, rise_en, fall_en, clr_r, clr_f;
  logic [CW-1:0] cnt [KEY_COUNT];
  logic [LED_COUNT-1:0] wd_led;
  logic [2:0] sel;
  logic wr;
  logic unused;
  assign sel = apb_PADDR[4:2];
  assign wr = apb_PSEL & apb_PENABLE & apb_PWRITE;
  assign wd_led = apb_PWDATA[LED_COUNT-1:0];
  assign clr_r = (wr && sel == 3'd2) ? apb_PWDATA[KEY_COUNT-1:0] : '0;
  assign clr_f = (wr && sel == 3'd2) ? apb_PWDATA[16 +: KEY_COUNT] : '0;
  assign apb_PREADY = 1'b1;
  assign leds = led_reg ^ LED_INVERT;
  assign unused = ^{apb_PADDR[1:0], apb_PWDATA};
  assign rise = hit & sync_b;
  assign fall = hit & ~sync_b;
  always_comb begin
    hit = '0;
    for (int i = 0; i < KEY_COUNT; i++)
      hit[i] = (sync_b[i] != state[i]) && (cnt[i] == CNT_MAX);
  end
  always_comb
    apb_PRDATA = sel == 3'd0 ? 32'(led_reg) :
                 sel == 3'd1 ? 32'(state) :
                 sel == 3'd2 ? {16'(fall_f), 16'(rise_f)} :
                 sel == 3'd3 ? {16'(fall_en), 16'(rise_en)} : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      led_reg <= '0;
      sync_a  <= '0;
      sync_b  <= '0;
      state   <= '0;
      rise_f  <= '0;
      fall_f  <= '0;
      rise_en <= '0;
      fall_en <= '0;
      irq     <= 1'b0;
      for (int i = 0; i < KEY_COUNT; i++) cnt[i] <= '0;
    end else begin
      sync_a <= keys ^ KEY_INVERT;
      sync_b <= sync_a;
      for (int i = 0; i < KEY_COUNT; i++)
        cnt[i] <= (sync_b[i] == state[i] || hit[i]) ? '0 : cnt[i] + CW'(1);
      state <= state ^ hit;
      led_reg <= !wr ? led_reg :
                 sel == 3'd0 ? wd_led :
                 sel == 3'd4 ? led_reg | wd_led :
                 sel == 3'd5 ? led_reg & ~wd_led : led_reg;
      rise_f <= (rise_f & ~clr_r) | rise;
      fall_f <= (fall_f & ~clr_f) | fall;
      rise_en <= (wr && sel == 3'd3) ? apb_PWDATA[KEY_COUNT-1:0] : rise_en;
      fall_en <= (wr && sel == 3'd3) ? apb_PWDATA[16 +: KEY_COUNT] : fall_en;
      irq <= |((rise_f & rise_en) | (fall_f & fall_en));
    end
  end
endmodule
